// File: rtl/sw_ctrl_pkg.sv
// Shared types and constants for the stopwatch run controller.
// Optional lap-hold feature is selected in the top level by STOPWATCH_LAP_EN.
package sw_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        ERROR = 3'd4,
        SAVER = 3'd5
    } sw_state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_ILL  = 2'b01;
    localparam logic [1:0] ERR_OVF  = 2'b10;
    localparam logic [1:0] ERR_UNF  = 2'b11;

    // States in which the user is considered inactive and the saver timer runs.
    function automatic logic is_quiet(input sw_state_t s);
        return (s == IDLE) || (s == PAUSE);
    endfunction

endpackage

// File: rtl/sw_idle_timer.sv
// Counts 1 Hz ticks of user inactivity; flags the tick that reaches IDLE_SECS.
module sw_idle_timer #(
    parameter int IDLE_SECS = 30,
    parameter int IDLE_W    = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic clr,
    input  logic cnt_en_i,
    output logic expired
);

    logic [IDLE_W-1:0] idle_cnt_r;
    logic              last_s;

    assign last_s  = (idle_cnt_r == IDLE_W'(IDLE_SECS - 1));
    assign expired = cnt_en_i & tick & ~clr & last_s;

    // Inactivity counter; wraps to zero on expiry so SAVER entry leaves it clean.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt_r <= '0;
        end else if (clr || !cnt_en_i) begin
            idle_cnt_r <= '0;
        end else if (tick) begin
            if (last_s) begin
                idle_cnt_r <= '0;
            end else begin
                idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_run_ctrl.sv
// Stopwatch sequencer: edge-detects switches, runs the mode FSM, drives counter and display selects.
// Define STOPWATCH_LAP_EN to enable the lap-hold toggle while running.
module stopwatch_run_ctrl
    import sw_ctrl_pkg::*;
#(
    parameter int IDLE_SECS = 30,
    parameter int IDLE_W    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1s,
    input  logic       start,
    input  logic       set,
    input  logic       mode,
    input  logic       illegal,
    input  logic       at_max,
    input  logic       at_zero,
    input  logic       lap,
    output logic       cnt_en,
    output logic       cnt_load,
    output logic       cnt_dir,
    output logic [1:0] err_code,
    output logic       disp_err,
    output logic       saver_on,
    output logic       lap_hold,
    output logic [2:0] state_o
);

    sw_state_t  state_r, state_s;
    logic [1:0] err_code_r, err_s;
    logic       cnt_dir_r, disp_err_r, saver_on_r;
    logic       start_q_r, set_q_r, mode_q_r;
    logic       start_rise_s, set_rise_s, mode_chg_s;
    logic       in_run_s, ovf_s, unf_s, quiet_s, idle_clr_s, expired_s;

    assign start_rise_s = start & ~start_q_r;
    assign set_rise_s   = set & ~set_q_r;
    assign mode_chg_s   = mode ^ mode_q_r;
    assign in_run_s     = (state_r == RUN);
    assign quiet_s      = is_quiet(state_r);
    assign idle_clr_s   = start_rise_s | set_rise_s | mode_chg_s;

    // Terminal-count checks use the direction latched on entry to RUN.
    assign ovf_s = in_run_s & tick_1s & cnt_dir_r & at_max;
    assign unf_s = in_run_s & tick_1s & ~cnt_dir_r & at_zero;

    sw_idle_timer #(
        .IDLE_SECS (IDLE_SECS),
        .IDLE_W    (IDLE_W)
    ) u_idle_timer (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick_1s),
        .clr      (idle_clr_s),
        .cnt_en_i (quiet_s),
        .expired  (expired_s)
    );

    // Next-state and error-code decode.
    always_comb begin
        state_s = state_r;
        err_s   = err_code_r;
        case (state_r)
            IDLE, PAUSE: begin
                if (set_rise_s) begin
                    if (illegal) begin
                        state_s = ERROR;
                        err_s   = ERR_ILL;
                    end else begin
                        state_s = LOAD;
                    end
                end else if (start_rise_s) begin
                    state_s = RUN;
                end else if (expired_s) begin
                    state_s = SAVER;
                end else begin
                    state_s = state_r;
                end
            end
            LOAD: begin
                state_s = PAUSE;
            end
            RUN: begin
                if (ovf_s) begin
                    state_s = ERROR;
                    err_s   = ERR_OVF;
                end else if (unf_s) begin
                    state_s = ERROR;
                    err_s   = ERR_UNF;
                end else if (start_rise_s) begin
                    state_s = PAUSE;
                end else begin
                    state_s = state_r;
                end
            end
            ERROR: begin
                if (set_rise_s) begin
                    state_s = IDLE;
                    err_s   = ERR_NONE;
                end else begin
                    state_s = state_r;
                end
            end
            SAVER: begin
                if (start_rise_s || set_rise_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = IDLE;
                err_s   = ERR_NONE;
            end
        endcase
    end

    // State, latched direction and registered display selects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            err_code_r <= ERR_NONE;
            cnt_dir_r  <= 1'b1;
            disp_err_r <= 1'b0;
            saver_on_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            err_code_r <= err_s;
            disp_err_r <= (state_s == ERROR);
            saver_on_r <= (state_s == SAVER);
            if (!in_run_s) begin
                cnt_dir_r <= mode;
            end
        end
    end

    // Previous switch levels for rise / change detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q_r <= 1'b0;
            set_q_r   <= 1'b0;
            mode_q_r  <= 1'b0;
        end else begin
            start_q_r <= start;
            set_q_r   <= set;
            mode_q_r  <= mode;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic lap_q_r, lap_hold_r, lap_rise_s;

    assign lap_rise_s = lap & ~lap_q_r;

    // Lap hold toggles only while staying in RUN; any exit clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_q_r    <= 1'b0;
            lap_hold_r <= 1'b0;
        end else begin
            lap_q_r <= lap;
            if (in_run_s && (state_s == RUN)) begin
                lap_hold_r <= lap_hold_r ^ lap_rise_s;
            end else begin
                lap_hold_r <= 1'b0;
            end
        end
    end

    assign lap_hold = lap_hold_r;
`else
    logic lap_unused_s;

    assign lap_unused_s = lap;
    assign lap_hold     = 1'b0;
`endif

    assign cnt_en   = in_run_s & tick_1s & ~ovf_s & ~unf_s;
    assign cnt_load = (state_r == LOAD);
    assign cnt_dir  = cnt_dir_r;
    assign err_code = err_code_r;
    assign disp_err = disp_err_r;
    assign saver_on = saver_on_r;
    assign state_o  = state_r;

endmodule

// File: tb/tb_stopwatch_run_ctrl.sv
// Scoreboard bench for stopwatch_run_ctrl: directed scenarios then randomized switch activity.
module tb_stopwatch_run_ctrl;

    localparam int IDLE_SECS = 30;
    localparam int IDLE_W    = 5;
    localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2, S_PAUSE = 3, S_ERROR = 4, S_SAVER = 5;

    logic       clk = 1'b0;
    logic       reset, tick_1s, start, set, mode, illegal, at_max, at_zero, lap;
    logic       cnt_en, cnt_load, cnt_dir, disp_err, saver_on, lap_hold;
    logic [1:0] err_code;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    stopwatch_run_ctrl #(.IDLE_SECS(IDLE_SECS), .IDLE_W(IDLE_W)) dut (
        .clk(clk), .reset(reset), .tick_1s(tick_1s), .start(start), .set(set),
        .mode(mode), .illegal(illegal), .at_max(at_max), .at_zero(at_zero), .lap(lap),
        .cnt_en(cnt_en), .cnt_load(cnt_load), .cnt_dir(cnt_dir), .err_code(err_code),
        .disp_err(disp_err), .saver_on(saver_on), .lap_hold(lap_hold), .state_o(state_o)
    );

    typedef struct {
        int         st;
        logic       en, ld, dir, de, sv, lh;
        logic [1:0] err;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   en_cnt = 0;

    // reference model: spec rules at the level of "what mode are we in"
    int         m_st, m_idle;
    logic       m_dir, m_lap;
    logic [1:0] m_err;
    logic       p_start, p_set, p_mode, p_lap;

    // stimulus levels applied on the next step
    logic g_rst, g_start, g_set, g_mode, g_ill, g_max, g_zero, g_lap;

    function automatic void model_reset();
        m_st = S_IDLE; m_idle = 0; m_dir = 1'b1; m_lap = 1'b0; m_err = 2'b00;
        p_start = 1'b0; p_set = 1'b0; p_mode = 1'b0; p_lap = 1'b0;
    endfunction

    function automatic void model_step();
        logic rs, rt, rl;
        int   nx;
        if (reset) begin
            model_reset();
            return;
        end
        rs = set & ~p_set;
        rt = start & ~p_start;
        rl = lap & ~p_lap;
        nx = m_st;
        case (m_st)
            S_IDLE, S_PAUSE: begin
                if (rs) begin
                    nx = illegal ? S_ERROR : S_LOAD;
                    if (illegal) m_err = 2'b01;
                end else if (rt) begin
                    nx = S_RUN;
                end else if (mode != p_mode) begin
                    m_idle = 0;
                end else if (tick_1s) begin
                    m_idle = m_idle + 1;
                    if (m_idle == IDLE_SECS) nx = S_SAVER;
                end
            end
            S_LOAD: nx = S_PAUSE;
            S_RUN: begin
                if (tick_1s && m_dir && at_max) begin
                    nx = S_ERROR; m_err = 2'b10;
                end else if (tick_1s && !m_dir && at_zero) begin
                    nx = S_ERROR; m_err = 2'b11;
                end else if (rt) begin
                    nx = S_PAUSE;
                end
            end
            S_ERROR: if (rs) begin nx = S_IDLE; m_err = 2'b00; end
            S_SAVER: if (rs || rt) nx = S_IDLE;
            default: nx = S_IDLE;
        endcase
        if (!((m_st == S_IDLE || m_st == S_PAUSE) && nx == m_st)) m_idle = 0;
        if (m_st != S_RUN) m_dir = mode;
`ifdef STOPWATCH_LAP_EN
        m_lap = (m_st == S_RUN && nx == S_RUN) ? (m_lap ^ rl) : 1'b0;
`else
        m_lap = 1'b0;
`endif
        m_st = nx;
        p_start = start; p_set = set; p_mode = mode; p_lap = lap;
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        e.st  = m_st;
        e.en  = (m_st == S_RUN) && tick_1s && !(m_dir && at_max) && !(!m_dir && at_zero);
        e.ld  = (m_st == S_LOAD);
        e.dir = m_dir;
        e.err = m_err;
        e.de  = (m_st == S_ERROR);
        e.sv  = (m_st == S_SAVER);
        e.lh  = m_lap;
        return e;
    endfunction

    function automatic void chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // one clock per iteration: model advances at the edge, new inputs and expectation after it
    task automatic step(input int n, input logic tk);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
            reset = g_rst; tick_1s = tk; start = g_start; set = g_set; mode = g_mode;
            illegal = g_ill; at_max = g_max; at_zero = g_zero; lap = g_lap;
            if (reset) model_reset();
            sb_q.push_back(expect_now());
        end
    endtask

    always @(negedge clk) if (cnt_en) en_cnt <= en_cnt + 1;

    // monitor: compare every presented output vector against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                n_vec++;
                if (int'(state_o) != e.st || cnt_en !== e.en || cnt_load !== e.ld ||
                    cnt_dir !== e.dir || err_code !== e.err || disp_err !== e.de ||
                    saver_on !== e.sv || lap_hold !== e.lh) begin
                    n_bad++;
                    $display("FAIL vec t=%0t: got st=%0d en=%b ld=%b dir=%b err=%b de=%b sv=%b lh=%b, expected st=%0d en=%b ld=%b dir=%b err=%b de=%b sv=%b lh=%b",
                             $time, state_o, cnt_en, cnt_load, cnt_dir, err_code, disp_err, saver_on, lap_hold,
                             e.st, e.en, e.ld, e.dir, e.err, e.de, e.sv, e.lh);
                end
            end
        end
    end

    initial begin
        int   en0;
        logic quiet;
        model_reset();
        g_rst = 1'b1; g_start = 1'b0; g_set = 1'b0; g_mode = 1'b1;
        g_ill = 1'b0; g_max = 1'b0; g_zero = 1'b0; g_lap = 1'b0;
        reset = 1'b1; tick_1s = 1'b0; start = 1'b0; set = 1'b0; mode = 1'b1;
        illegal = 1'b0; at_max = 1'b0; at_zero = 1'b0; lap = 1'b0;
        step(2, 1'b0);
        #1;
        chk("reset_state", int'(state_o), S_IDLE);
        chk("reset_dir", int'(cnt_dir), 1);
        g_rst = 1'b0;
        step(2, 1'b0);

        // legal load, then run three seconds
        g_set = 1'b1; step(1, 1'b0); g_set = 1'b0; step(1, 1'b0);
        #1 chk("load_pulse", int'(cnt_load), 1);
        step(1, 1'b0);
        #1 chk("load_then_pause", int'(state_o), S_PAUSE);
        en0 = en_cnt;
        g_start = 1'b1; step(1, 1'b0); g_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1, 1'b1); step(2, 1'b0);
        end
        chk("three_ticks", en_cnt - en0, 3);

        // asynchronous reset while running with a tick present
        g_rst = 1'b1; step(1, 1'b1);
        #1;
        chk("rst_state", int'(state_o), S_IDLE);
        chk("rst_cnt_en", int'(cnt_en), 0);
        chk("rst_cnt_load", int'(cnt_load), 0);
        chk("rst_cnt_dir", int'(cnt_dir), 1);
        step(1, 1'b0); g_rst = 1'b0; step(2, 1'b0);

        // illegal set -> ERROR, start ignored, set recovers
        g_ill = 1'b1; g_set = 1'b1; step(1, 1'b0); g_set = 1'b0; step(1, 1'b0);
        g_start = 1'b1; step(1, 1'b0); g_start = 1'b0; step(1, 1'b0);
        #1;
        chk("ill_err", int'(err_code), 1);
        chk("ill_disp", int'(disp_err), 1);
        g_ill = 1'b0;
        g_set = 1'b1; step(1, 1'b0); g_set = 1'b0; step(1, 1'b0);
        #1 chk("ill_clear", int'(err_code), 0);

        // overflow counting up
        g_start = 1'b1; step(1, 1'b0); g_start = 1'b0; step(1, 1'b0);
        g_max = 1'b1; step(1, 1'b1);
        #1 chk("ovf_no_en", int'(cnt_en), 0);
        g_max = 1'b0; step(1, 1'b0);
        #1 chk("ovf_err", int'(err_code), 2);
        g_set = 1'b1; step(1, 1'b0); g_set = 1'b0; step(1, 1'b0);

        // underflow counting down
        g_mode = 1'b0; step(1, 1'b0);
        g_start = 1'b1; step(1, 1'b0); g_start = 1'b0; step(1, 1'b0);
        g_zero = 1'b1; step(1, 1'b1); g_zero = 1'b0; step(1, 1'b0);
        #1 chk("unf_err", int'(err_code), 3);
        g_set = 1'b1; step(1, 1'b0); g_set = 1'b0; step(1, 1'b0);

        // idle timeout boundary: 29 ticks stay idle, 30th enters SAVER
        for (int i = 0; i < 29; i++) begin
            step(1, 1'b1); step(1, 1'b0);
        end
        #1 chk("saver_29", int'(saver_on), 0);
        step(1, 1'b1); step(1, 1'b0);
        #1;
        chk("saver_30", int'(saver_on), 1);
        chk("saver_state", int'(state_o), S_SAVER);
        g_start = 1'b1; step(1, 1'b0); g_start = 1'b0; step(2, 1'b0);
        #1 chk("saver_wake_idle", int'(state_o), S_IDLE);
        g_start = 1'b1; g_set = 1'b1; step(1, 1'b0); g_start = 1'b0; g_set = 1'b0; step(1, 1'b0);
        #1 chk("set_beats_start", int'(state_o), S_LOAD);
        step(1, 1'b0);

`ifdef STOPWATCH_LAP_EN
        g_start = 1'b1; step(1, 1'b0); g_start = 1'b0; step(1, 1'b0);
        g_lap = 1'b1; step(1, 1'b0); g_lap = 1'b0; step(1, 1'b1);
        #1;
        chk("lap_hold_set", int'(lap_hold), 1);
        chk("lap_counting", int'(cnt_en), 1);
        g_start = 1'b1; step(1, 1'b0); g_start = 1'b0; step(1, 1'b0);
        #1 chk("lap_clear_pause", int'(lap_hold), 0);
`endif

        // randomized activity: busy segments toggle switches, quiet ones let the saver fire
        for (int s = 0; s < 40; s++) begin
            quiet = ($urandom_range(0, 2) == 0);
            for (int c = 0; c < 50; c++) begin
                if (!quiet) begin
                    if ($urandom_range(0, 5) == 0) g_start = ~g_start;
                    if ($urandom_range(0, 5) == 0) g_set = ~g_set;
                    if ($urandom_range(0, 9) == 0) g_mode = ~g_mode;
                    if ($urandom_range(0, 3) == 0) g_lap = ~g_lap;
                end
                g_ill  = 1'($urandom_range(0, 1));
                g_max  = ($urandom_range(0, 7) == 0);
                g_zero = ($urandom_range(0, 7) == 0);
                g_rst  = ($urandom_range(0, 299) == 0);
                step(1, ($urandom_range(0, 2) == 0) || (quiet && $urandom_range(0, 1) == 0));
            end
        end

        g_rst = 1'b0;
        step(2, 1'b0);
        @(negedge clk);
        #1 chk("sb_drain", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
